// File: rtl/approx_mul_error_monitor_pkg.sv
// Shared types and width helpers for the approximate-multiplier error monitor.
package approx_mul_error_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_e;

  localparam int DRAIN_CYCLES = 2;

  // The sum accumulator holds 2^IN_W values of up to 2^OUT_W-1, so it never wraps.
  function automatic int sum_w(input int in_w, input int out_w);
    return out_w + in_w;
  endfunction

  function automatic int cnt_w(input int in_w);
    return in_w + 1;
  endfunction

endpackage

// File: rtl/approx_mul_error_monitor_err_stage.sv
// Two-stage pipeline: S1 captures exact product and DUT response, S2 the absolute error.
module approx_err_stage #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             err_valid,
  output logic [OUT_W-1:0] abs_err
);

  localparam int OP_W = IN_W / 2;

  logic [OUT_W-1:0] s1_exact_d, s1_exact_q;
  logic [OUT_W-1:0] s1_out_d,   s1_out_q;
  logic             s1_valid_d, s1_valid_q;
  logic [OUT_W-1:0] s2_err_d,   s2_err_q;
  logic             s2_valid_d, s2_valid_q;

  always_comb begin
    s1_exact_d = OUT_W'(dut_in[OP_W-1:0]) * OUT_W'(dut_in[IN_W-1:OP_W]);
    s1_out_d   = dut_out;
    s1_valid_d = in_valid;
    s2_err_d   = (s1_exact_q >= s1_out_q) ? (s1_exact_q - s1_out_q)
                                          : (s1_out_q - s1_exact_q);
    s2_valid_d = s1_valid_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_exact_q <= '0;
      s1_out_q   <= '0;
      s1_valid_q <= 1'b0;
      s2_err_q   <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_exact_q <= s1_exact_d;
      s1_out_q   <= s1_out_d;
      s1_valid_q <= s1_valid_d;
      s2_err_q   <= s2_err_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign err_valid = s2_valid_q;
  assign abs_err   = s2_err_q;

endmodule

// File: rtl/approx_mul_error_monitor.sv
// Sweeps every input vector through an approximate multiplier and accumulates error statistics.
module approx_mul_error_monitor
  import approx_mul_error_monitor_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 4,
  parameter int ET    = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic [IN_W-1:0]                dut_in,
  input  logic [OUT_W-1:0]               dut_out,
  output logic                           busy,
  output logic                           done,
  output logic [OUT_W-1:0]               max_err,
  output logic [cnt_w(IN_W)-1:0]         err_count,
  output logic [sum_w(IN_W, OUT_W)-1:0]  sum_err,
  output logic                           pass
);

  localparam int CNT_W   = cnt_w(IN_W);
  localparam int SUM_W   = sum_w(IN_W, OUT_W);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0]   LAST_VEC   = CNT_W'((2 ** IN_W) - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);

  mon_state_e         state_d, state_q;
  logic [CNT_W-1:0]   vec_d, vec_q;
  logic [DRAIN_W-1:0] drain_d, drain_q;
  logic [OUT_W-1:0]   max_err_d, max_err_q;
  logic [CNT_W-1:0]   err_count_d, err_count_q;
  logic [SUM_W-1:0]   sum_err_d, sum_err_q;
  logic               pass_d, pass_q;
  logic               pass_now;
  logic               err_valid;
  logic [OUT_W-1:0]   abs_err;

  approx_err_stage #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_err_stage (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (state_q == SWEEP),
    .dut_in    (vec_q[IN_W-1:0]),
    .dut_out   (dut_out),
    .err_valid (err_valid),
    .abs_err   (abs_err)
  );

  assign pass_now = (32'(max_err_q) <= 32'(ET));

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    drain_d     = drain_q;
    max_err_d   = max_err_q;
    err_count_d = err_count_q;
    sum_err_d   = sum_err_q;
    pass_d      = pass_q;

    if (err_valid) begin
      if (abs_err > max_err_q) max_err_d = abs_err;
      err_count_d = err_count_q + CNT_W'(abs_err != '0);
      sum_err_d   = sum_err_q + SUM_W'(abs_err);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SWEEP;
          vec_d       = '0;
          max_err_d   = '0;
          err_count_d = '0;
          sum_err_d   = '0;
          pass_d      = 1'b0;
        end
      end
      SWEEP: begin
        // The last vector stays on dut_in while the pipeline drains.
        if (vec_q == LAST_VEC) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          vec_d = vec_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) state_d = DONE;
        else                       drain_d = drain_q + 1'b1;
      end
      DONE: begin
        pass_d  = pass_now;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      drain_q     <= '0;
      max_err_q   <= '0;
      err_count_q <= '0;
      sum_err_q   <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      drain_q     <= drain_d;
      max_err_q   <= max_err_d;
      err_count_q <= err_count_d;
      sum_err_q   <= sum_err_d;
      pass_q      <= pass_d;
    end
  end

  assign dut_in    = vec_q[IN_W-1:0];
  assign busy      = (state_q == SWEEP) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign max_err   = max_err_q;
  assign err_count = err_count_q;
  assign sum_err   = sum_err_q;
  // The verdict is visible in the DONE cycle itself, then held in IDLE.
  assign pass      = (state_q == DONE) ? pass_now : pass_q;

endmodule

// File: doc/approx_mul_error_monitor.md
Name: approx_mul_error_monitor

Overview:
- Sequential error-characterisation stage placed directly downstream of a generated approximate multiplier netlist (e.g. 4-in/4-out, lpp/ppo-bounded SOP variant).
- Drives every input vector into the combinational approximate multiplier and consumes its outputs.
- Compares each output against the exact product and accumulates error statistics.
- Reports a pass/fail verdict against the error threshold ET used at synthesis time.

Parameters:
- IN_W, 4, total DUT input bits; operand A = dut_in[IN_W/2-1:0], operand B = dut_in[IN_W-1:IN_W/2]; must be even.
- OUT_W, 4, DUT output bits; must equal IN_W (full product width).
- ET, 5, maximum tolerated absolute error; verdict threshold.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- dut_in  output  IN_W  vector driven into the approximate multiplier (registered).
- dut_out  input  OUT_W  combinational response of the approximate multiplier to dut_in.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle pulse when results are final.
- max_err  output  OUT_W  largest |exact - dut_out| seen in the sweep.
- err_count  output  IN_W+1  number of vectors with nonzero error.
- sum_err  output  OUT_W+IN_W  sum of absolute errors over all vectors.
- pass  output  1  max_err <= ET; valid when done or in IDLE after a sweep.

Behaviour:
- Reset (async, any state): FSM=IDLE; dut_in=0, busy=0, done=0, max_err=0, err_count=0, sum_err=0, pass=0; pipeline valid bits cleared. A reset mid-sweep abandons the sweep with no done pulse.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - start=1 clears all accumulators, dut_in=0, pass=0, and moves to SWEEP.
  - Previous results are held until then.
- SWEEP:
  - Each cycle, dut_in presents vector k, for k = 0 .. 2^IN_W-1; the counter is IN_W+1 bits so there is no wrap ambiguity.
  - After vector 2^IN_W-1 is presented, go to DRAIN; dut_in holds that last vector.
- Pipeline:
  - S1 registers {A*B exact, dut_out, valid} at the end of the cycle dut_in is presented.
  - S2 registers abs_err = |exact - dut_out| (OUT_W bits, unsigned compare/subtract) plus valid.
  - Accumulators update from S2 when valid: max_err = max(max_err, abs_err); err_count += (abs_err != 0); sum_err += abs_err.
  - sum_err never overflows: its max is (2^IN_W)*(2^OUT_W-1) < 2^(OUT_W+IN_W).
- DRAIN: exactly 2 cycles, flushing S1/S2; then DONE.
- DONE: done=1 for one cycle; pass updated; busy=0 in this cycle; next state IDLE.
- Latency: start accepted at cycle 0; SWEEP covers cycles 1..2^IN_W; DRAIN covers 2^IN_W+1..2^IN_W+2; done at cycle 2^IN_W+3 (cycle 19 for IN_W=4).
- start while busy or in DONE is ignored; it is not queued.
- start in the cycle after DONE (back in IDLE) begins a fresh sweep and clears results.
- dut_out is sampled only through S1; its value outside SWEEP/first DRAIN cycle is don't-care.

Decomposition:
- Shared package holds:
  - FSM state enum {IDLE, SWEEP, DRAIN, DONE};
  - localparam DRAIN_CYCLES=2;
  - width helper functions for accumulator widths (sum width = OUT_W+IN_W, count width = IN_W+1).
- One natural sub-module: approx_err_stage, the S1/S2 exact-product and absolute-error pipeline with a valid bit.
- FSM and accumulators stay in the top.

Test Plan:
- Exact DUT (dut_out = A*B), IN_W=4: start -> done at cycle 19; max_err=0, err_count=0, sum_err=0, pass=1; dut_in visited 0..15 exactly once.
- Constant-zero DUT: start -> max_err=9, err_count=9, sum_err=36, pass=0 (ET=5).
- DUT = (A*B) XOR 1: start -> max_err=1, err_count=16, sum_err=16, pass=1.
- Assert rst during SWEEP at vector 7 -> all outputs 0 immediately (async); no done pulse; a later start gives a full correct sweep.
- start pulsed during SWEEP and during DONE -> ignored: single done pulse, counts unchanged versus a clean run.
- Back-to-back: constant-zero sweep, then start one cycle after done with exact DUT -> second sweep reports max_err=0, sum_err=0, pass=1 (accumulators cleared).
